// File: rtl/wisc_cache_pkg.sv
// wisc_cache_pkg: shared types and block geometry for the WISC cache fill path
package wisc_cache_pkg;
    typedef enum logic {IDLE, FILL} fill_state_t;
    localparam int BLOCK_WORDS = 8;
    localparam int OFFSET_BITS = $clog2(BLOCK_WORDS);
    localparam logic [15:0] BLOCK_BYTE_MASK = 16'((BLOCK_WORDS << 1) - 1);
    localparam int MEM_LATENCY = 4;
endpackage

// File: rtl/fill_counter.sv
// fill_counter: word counter for one side of a block fill.
// Ports: clk, rst (async active-low), clr (sync clear), en (count enable),
//        cnt (current word index), done (set once all 2**W words are counted).
module fill_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         done
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (en && !done) begin
            cnt  <= cnt + 1'b1;
            done <= &cnt;
        end
    end
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches a missing cache block from pipelined memory and writes it into the cache.
// Ports: clk, rst (async active-low); miss_detected/miss_address start a fill;
//        memory_request/memory_address issue word reads, memory_valid/memory_data_out return them;
//        write_data_array/fill_address/fill_data write each returned word;
//        write_tag_array/fill_done pulse on the last word; fsm_busy stalls the pipeline.
module cache_fill_fsm
    import wisc_cache_pkg::fill_state_t, wisc_cache_pkg::IDLE, wisc_cache_pkg::FILL;
#(
    parameter int AWIDTH      = 16,
    parameter int DWIDTH      = 16,
    parameter int BLOCK_WORDS = wisc_cache_pkg::BLOCK_WORDS,
    parameter int MEM_LATENCY = wisc_cache_pkg::MEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [AWIDTH-1:0] miss_address,
    input  logic [DWIDTH-1:0] memory_data_out,
    input  logic              memory_valid,
    output logic              memory_request,
    output logic [AWIDTH-1:0] memory_address,
    output logic              fsm_busy,
    output logic              write_data_array,
    output logic [AWIDTH-1:0] fill_address,
    output logic [DWIDTH-1:0] fill_data,
    output logic              write_tag_array,
    output logic              fill_done
);
    localparam int CW = $clog2(BLOCK_WORDS);
    localparam logic [AWIDTH-1:0] OFF_MASK = AWIDTH'(2 * BLOCK_WORDS - 1);

    // The fill only counts returns, so latency is free; a block must still split into 2**CW words.
    if ((BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0 || BLOCK_WORDS < 2 || MEM_LATENCY < 1) begin : g_bad_cfg
        $error("cache_fill_fsm: BLOCK_WORDS must be a power of two >= 2 and MEM_LATENCY >= 1");
    end

    fill_state_t       state;
    logic [AWIDTH-1:0] base;
    logic [CW-1:0]     issue_cnt, recv_cnt;
    logic              issue_done, recv_done, busy;

    assign busy             = state == FILL;
    assign fsm_busy         = busy;
    assign memory_request   = busy && !issue_done;
    assign write_data_array = busy && memory_valid && !recv_done;
    assign fill_done        = write_data_array && &recv_cnt;
    assign write_tag_array  = fill_done;
    assign fill_data        = memory_data_out;
    // Addresses read zero outside a fill so reset and idle look identical downstream.
    assign memory_address   = busy ? base + AWIDTH'({issue_cnt, 1'b0}) : '0;
    assign fill_address     = busy ? base + AWIDTH'({recv_cnt, 1'b0}) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            base  <= '0;
        end else if (!busy) begin
            if (miss_detected) begin
                state <= FILL;
                base  <= miss_address & ~OFF_MASK;
            end
        end else if (fill_done) begin
            state <= IDLE;
        end
    end

    // Both counters sit cleared while idle, so stray returns there cannot advance them.
    fill_counter #(.W(CW)) u_issue (
        .clk (clk),
        .rst (rst),
        .clr (!busy),
        .en  (memory_request),
        .cnt (issue_cnt),
        .done(issue_done)
    );

    fill_counter #(.W(CW)) u_recv (
        .clk (clk),
        .rst (rst),
        .clr (!busy),
        .en  (write_data_array),
        .cnt (recv_cnt),
        .done(recv_done)
    );
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: scoreboard bench for cache_fill_fsm with a variable-latency memory model
module tb_cache_fill_fsm;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic [15:0] memory_data_out = '0;
    logic        memory_valid = 1'b0;
    logic        memory_request, fsm_busy, write_data_array, write_tag_array, fill_done;
    logic [15:0] memory_address, fill_address, fill_data;

    cache_fill_fsm dut (
        .clk             (clk),
        .rst             (rst),
        .miss_detected   (miss_detected),
        .miss_address    (miss_address),
        .memory_data_out (memory_data_out),
        .memory_valid    (memory_valid),
        .memory_request  (memory_request),
        .memory_address  (memory_address),
        .fsm_busy        (fsm_busy),
        .write_data_array(write_data_array),
        .fill_address    (fill_address),
        .fill_data       (fill_data),
        .write_tag_array (write_tag_array),
        .fill_done       (fill_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          c;
        logic [15:0] a;
    } ret_t;

    ret_t        rq[$];
    logic [15:0] exp_a[$];
    logic [15:0] exp_d[$];
    int          nchk = 0, nerr = 0;
    int          cyc = 0, last_ret = 0, gmax = 0;
    int          req_n = 0, wr_n = 0, first_req = -1, done_cyc = -1;
    bit          tb_busy = 0, stray = 0;
    logic [15:0] exp_base = '0, last_req = '0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        bit          mv, exp_req, exp_wr, exp_done;
        int          c;
        logic [15:0] a;
        ret_t        r;
        mv = rq.size() > 0 && rq[0].c == cyc;
        memory_valid = mv | stray;
        memory_data_out = mv ? mem_word(rq[0].a) : 16'($urandom);
        #4;
        exp_req = tb_busy && req_n < 8;
        exp_wr  = mv && tb_busy;
        check("busy", fsm_busy, tb_busy);
        check("req", memory_request, exp_req);
        check("wr_strobe", write_data_array, exp_wr);
        check("fill_data", fill_data, memory_data_out);
        if (exp_req) begin
            if (first_req < 0) first_req = cyc;
            a = exp_base + 16'(2 * req_n);
            check("req_addr", memory_address, a);
            last_req = memory_address;
            c = cyc + LAT + (gmax > 0 ? int'($urandom_range(gmax, 0)) : 0);
            if (c <= last_ret) c = last_ret + 1;
            last_ret = c;
            r.c = c;
            r.a = a;
            rq.push_back(r);
            exp_a.push_back(a);
            exp_d.push_back(mem_word(a));
            req_n++;
        end
        if (exp_wr) begin
            if (exp_a.size() == 0) check("wr_unexpected", 1, 0);
            else begin
                check("fill_addr", fill_address, exp_a.pop_front());
                check("wr_data", fill_data, exp_d.pop_front());
            end
            wr_n++;
        end
        exp_done = exp_wr && wr_n == 8;
        check("fill_done", fill_done, exp_done);
        check("tag_write", write_tag_array, exp_done);
        if (exp_done) done_cyc = cyc;
        if (mv) void'(rq.pop_front());
        @(posedge clk);
        #1;
        cyc++;
        if (exp_done) tb_busy = 0;
    endtask

    task automatic do_fill(input logic [15:0] addr, input int gmax_i, input bit toggle, input int stop_at);
        int budget;
        gmax = gmax_i;
        miss_detected = 1'b1;
        miss_address = addr;
        tick();
        exp_base = addr & 16'hFFF0;
        req_n = 0;
        wr_n = 0;
        first_req = -1;
        done_cyc = -1;
        tb_busy = 1;
        miss_detected = 1'b0;
        if (toggle) miss_address = 16'h8000;
        budget = 0;
        while (tb_busy && budget < 80 && !(stop_at > 0 && wr_n >= stop_at)) begin
            tick();
            budget++;
        end
        if (budget >= 80) check("fill_timeout", 1, 0);
        if (stop_at == 0) begin
            check("req_count", req_n, 8);
            check("wr_count", wr_n, 8);
            check("sb_empty", exp_a.size(), 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobes"}, {memory_request, write_data_array, write_tag_array, fill_done, fsm_busy}, 0);
        check({tag, "_maddr"}, memory_address, 0);
        check({tag, "_faddr"}, fill_address, 0);
        check({tag, "_fdata"}, fill_data, memory_data_out);
    endtask

    initial begin
        int mc;
        memory_data_out = 16'hBEEF;
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        last_ret = cyc;

        mc = cyc;
        do_fill(16'h1234, 0, 0, 0);
        check("first_req_cycle", first_req - mc, 1);
        check("done_cycle", done_cyc - mc, 12);

        do_fill(16'hFFFF, 0, 0, 0);
        check("top_block_last_req", last_req, 16'hFFFE);

        stray = 1;
        repeat (3) tick();
        stray = 0;
        do_fill(16'h0A56, 0, 0, 0);

        for (int i = 0; i < 4; i++) do_fill(16'($urandom), 3, 0, 0);

        do_fill(16'h2000, 1, 1, 0);
        check("toggle_last_req", last_req, 16'h200E);

        do_fill(16'h5678, 0, 0, 4);
        memory_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_outputs("midfill_reset");
        rq.delete();
        exp_a.delete();
        exp_d.delete();
        tb_busy = 0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        last_ret = cyc;
        do_fill(16'h0040, 0, 0, 0);
        check("post_reset_last_req", last_req, 16'h004E);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
